// File: rtl/uart_alu_ctrl.sv
// uart_alu_ctrl: byte-stream packet controller between uart_rx/uart_tx AXI-Stream
// ports and an external 32-bit ALU. Parses a 4-byte header (opcode, reserved,
// LEN little-endian). Echo payloads pass straight through. ADD/MUL payload words
// are folded into an accumulator through the ALU handshake, and the 32-bit
// result is returned little-endian.
module uart_alu_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic [1:0]  alu_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic        alu_valid,
    input  logic        alu_ready,
    input  logic        alu_done,
    input  logic [31:0] alu_result,
    output logic        busy,
    output logic        err
);
    localparam logic [7:0] OP_ECHO = 8'hEC;
    localparam logic [7:0] OP_ADD  = 8'hAD;
    localparam logic [7:0] OP_MUL  = 8'h88;

    typedef enum logic [3:0] {
        S_HDR0     = 4'd0,
        S_HDR1     = 4'd1,
        S_HDR2     = 4'd2,
        S_HDR3     = 4'd3,
        S_DISPATCH = 4'd4,
        S_ECHO     = 4'd5,
        S_COLLECT  = 4'd6,
        S_ALU_REQ  = 4'd7,
        S_ALU_WAIT = 4'd8,
        S_SEND     = 4'd9,
        S_DRAIN    = 4'd10
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [7:0]  opcode_r;
    logic [15:0] len_r;
    logic [15:0] rem_r;
    logic [31:0] word_r;
    logic [31:0] acc_r;
    logic [1:0]  byte_cnt_r;
    logic [1:0]  send_idx_r;
    logic        first_r;

    logic        s_fire_s;
    logic        m_fire_s;
    logic        is_echo_s;
    logic        is_alu_s;
    logic        len_short_s;
    logic        len_is4_s;
    logic [15:0] pay_s;
    logic        misalign_s;
    logic        dispatch_err_s;
    logic [31:0] word_nxt_s;

    // Select one little-endian byte of a 32-bit word.
    function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            2'd3:    b = w[31:24];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

    assign s_fire_s       = s_axis_tvalid & s_axis_tready;
    assign m_fire_s       = m_axis_tvalid & m_axis_tready;
    assign is_echo_s      = (opcode_r == OP_ECHO);
    assign is_alu_s       = (opcode_r == OP_ADD) | (opcode_r == OP_MUL);
    assign len_short_s    = (len_r < 16'd4);
    assign len_is4_s      = (len_r == 16'd4);
    assign pay_s          = len_r - 16'd4;
    assign misalign_s     = (pay_s[1:0] != 2'd0);
    // A short LEN is always an error; ALU packets also need whole 32-bit words.
    assign dispatch_err_s = len_short_s | (is_alu_s & misalign_s) | (~is_alu_s & ~is_echo_s);
    // Operand bytes arrive LSB first, so each new byte enters at the top.
    assign word_nxt_s     = {s_axis_tdata, word_r[31:8]};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_HDR0;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state selection.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_HDR0:     if (s_fire_s) state_nxt_s = S_HDR1;     else state_nxt_s = S_HDR0;
            S_HDR1:     if (s_fire_s) state_nxt_s = S_HDR2;     else state_nxt_s = S_HDR1;
            S_HDR2:     if (s_fire_s) state_nxt_s = S_HDR3;     else state_nxt_s = S_HDR2;
            S_HDR3:     if (s_fire_s) state_nxt_s = S_DISPATCH; else state_nxt_s = S_HDR3;
            S_DISPATCH: begin
                if (len_short_s) begin
                    state_nxt_s = S_HDR0;
                end else if (is_echo_s) begin
                    state_nxt_s = len_is4_s ? S_HDR0 : S_ECHO;
                end else if (is_alu_s) begin
                    if (misalign_s)     state_nxt_s = S_DRAIN;
                    else if (len_is4_s) state_nxt_s = S_SEND;
                    else                state_nxt_s = S_COLLECT;
                end else begin
                    state_nxt_s = len_is4_s ? S_HDR0 : S_DRAIN;
                end
            end
            S_ECHO, S_DRAIN: begin
                if (s_fire_s && rem_r == 16'd1) state_nxt_s = S_HDR0;
                else                            state_nxt_s = state_r;
            end
            S_COLLECT: begin
                if (s_fire_s && byte_cnt_r == 2'd3) begin
                    if (!first_r)            state_nxt_s = S_ALU_REQ;
                    else if (rem_r == 16'd1) state_nxt_s = S_SEND;
                    else                     state_nxt_s = S_COLLECT;
                end else begin
                    state_nxt_s = S_COLLECT;
                end
            end
            S_ALU_REQ:  if (alu_ready) state_nxt_s = S_ALU_WAIT; else state_nxt_s = S_ALU_REQ;
            S_ALU_WAIT: begin
                if (alu_done) state_nxt_s = (rem_r == 16'd0) ? S_SEND : S_COLLECT;
                else          state_nxt_s = S_ALU_WAIT;
            end
            S_SEND: begin
                if (m_fire_s && send_idx_r == 2'd3) state_nxt_s = S_HDR0;
                else                                state_nxt_s = S_SEND;
            end
            default:    state_nxt_s = S_HDR0;
        endcase
    end

    // Header fields, payload counter, operand word and accumulator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opcode_r   <= 8'd0;
            len_r      <= 16'd0;
            rem_r      <= 16'd0;
            word_r     <= 32'd0;
            acc_r      <= 32'd0;
            byte_cnt_r <= 2'd0;
            send_idx_r <= 2'd0;
            first_r    <= 1'b0;
        end else begin
            case (state_r)
                S_HDR0: if (s_fire_s) opcode_r    <= s_axis_tdata;
                S_HDR2: if (s_fire_s) len_r[7:0]  <= s_axis_tdata;
                S_HDR3: if (s_fire_s) len_r[15:8] <= s_axis_tdata;
                S_DISPATCH: begin
                    rem_r      <= pay_s;
                    acc_r      <= 32'd0;
                    first_r    <= 1'b1;
                    byte_cnt_r <= 2'd0;
                    send_idx_r <= 2'd0;
                end
                S_ECHO, S_DRAIN: if (s_fire_s) rem_r <= rem_r - 16'd1;
                S_COLLECT: begin
                    if (s_fire_s) begin
                        rem_r      <= rem_r - 16'd1;
                        word_r     <= word_nxt_s;
                        byte_cnt_r <= byte_cnt_r + 2'd1;
                        // The first complete word seeds the accumulator directly.
                        if (byte_cnt_r == 2'd3 && first_r) begin
                            acc_r   <= word_nxt_s;
                            first_r <= 1'b0;
                        end
                    end
                end
                S_ALU_WAIT: if (alu_done) acc_r <= alu_result;
                S_SEND:     if (m_fire_s) send_idx_r <= send_idx_r + 2'd1;
                default:    ;
            endcase
        end
    end

    // Output decode from the current state (echo is a combinational pass-through).
    always_comb begin
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = 8'd0;
        alu_valid     = 1'b0;
        alu_op        = 2'd0;
        alu_a         = 32'd0;
        alu_b         = 32'd0;
        busy          = 1'b1;
        err           = 1'b0;
        case (state_r)
            S_HDR0: begin
                s_axis_tready = 1'b1;
                busy          = 1'b0;
            end
            S_HDR1, S_HDR2, S_HDR3, S_COLLECT, S_DRAIN: s_axis_tready = 1'b1;
            S_DISPATCH: err = dispatch_err_s;
            S_ECHO: begin
                m_axis_tdata  = s_axis_tdata;
                m_axis_tvalid = s_axis_tvalid;
                s_axis_tready = m_axis_tready;
            end
            S_ALU_REQ: begin
                alu_valid = 1'b1;
                alu_a     = acc_r;
                alu_b     = word_r;
                alu_op    = (opcode_r == OP_MUL) ? 2'd1 : 2'd0;
            end
            S_SEND: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = byte_sel(acc_r, send_idx_r);
            end
            default: busy = 1'b1;
        endcase
    end
endmodule

// File: doc/uart_alu_ctrl.md
# uart_alu_ctrl

Packet controller between the UART receive and transmit AXI-Stream ports and the 32-bit ALU datapath. It parses byte-wise command packets from `uart_rx`, forwards echo payloads straight to `uart_tx`, and sequences multi-operand ADD/MUL commands through an external ALU with a request/acknowledge handshake. It returns the 32-bit result little-endian, then waits for the next packet.

## Interface
- `OP_ECHO`, 8'hEC: echo opcode.
- `OP_ADD`, 8'hAD: sum opcode (ALU op 2'd0).
- `OP_MUL`, 8'h88: product opcode (ALU op 2'd1).
- `clk`  in  1  single clock, all state on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `s_axis_tdata`  in  8  byte from uart_rx.
- `s_axis_tvalid`  in  1  byte valid.
- `s_axis_tready`  out  1  byte accepted when valid & ready.
- `m_axis_tdata`  out  8  byte to uart_tx.
- `m_axis_tvalid`  out  1  byte valid.
- `m_axis_tready`  in  1  uart_tx ready.
- `alu_op`  out  2  operation, held with `alu_valid`.
- `alu_a`, `alu_b`  out  32 each  operands (a = accumulator, b = new word).
- `alu_valid`  out  1  request; held until `alu_ready`.
- `alu_ready`  in  1  request accepted.
- `alu_done`  in  1  one-cycle pulse; `alu_result` valid.
- `alu_result`  in  32  result (low 32 bits; overflow discarded by ALU).
- `busy`  out  1  high in every state except HDR0.
- `err`  out  1  one-cycle pulse on malformed or unknown packet.

## Operation
- Packet layout: byte0 opcode, byte1 reserved (ignored), byte2 LEN[7:0], byte3 LEN[15:8].
- LEN is the total packet length including the 4 header bytes. Payload = LEN-4 bytes.
- States: HDR0, HDR1, HDR2, HDR3, DISPATCH, ECHO, COLLECT, ALU_REQ, ALU_WAIT, SEND, DRAIN.
- HDR0..HDR3: `s_axis_tready`=1; latch opcode and LEN; advance one state per accepted byte.
- DISPATCH (one cycle) selects the next state:
  - LEN<4: `err` pulse, then HDR0.
  - Opcode OP_ECHO: LEN==4 goes to HDR0, otherwise ECHO.
  - Opcode ADD/MUL with (LEN-4) not a multiple of 4: `err` pulse, then DRAIN.
  - Opcode ADD/MUL, LEN==4: acc=0, then SEND.
  - Opcode ADD/MUL, otherwise: COLLECT, with first-word flag set.
  - Any other opcode: `err` pulse, then DRAIN (HDR0 if LEN==4).
- ECHO: combinational pass-through, with `m_axis_tdata`=`s_axis_tdata`, `m_axis_tvalid`=`s_axis_tvalid`, `s_axis_tready`=`m_axis_tready`. A 16-bit remaining counter decrements per transfer. At 0, go to HDR0.
- COLLECT: `s_axis_tready`=1. Shift 4 bytes LSB-first into the word register.
  - On the 4th byte with the first-word flag set: acc=word, clear the flag. If no payload remains, go to SEND; otherwise stay in COLLECT.
  - On the 4th byte otherwise: go to ALU_REQ.
- ALU_REQ: `alu_valid`=1, `alu_a`=acc, `alu_b`=word, `alu_op` from the opcode. On `alu_ready`, go to ALU_WAIT.
- ALU_WAIT: `s_axis_tready`=0. On `alu_done`, acc=`alu_result`. Go to SEND if the remaining count is 0, else COLLECT.
- SEND: emit acc[7:0], [15:8], [23:16], [31:24]. Each byte is held stable until `m_axis_tready`. After the 4th byte, go to HDR0.
- DRAIN: `s_axis_tready`=1; discard the remaining payload bytes, then go to HDR0.
- Reset values: state HDR0, and `s_axis_tready`=1. All of these are 0: `m_axis_tvalid`, `m_axis_tdata`, `alu_valid`, `alu_op`, `alu_a`, `alu_b`, `busy`, `err`, acc, counters.
- Reset mid-packet: abandons the packet and any outstanding ALU request. A late `alu_done` in HDR0 is ignored.

## Timing
- Header parse plus dispatch: 5 cycles minimum when `s_axis_tvalid` is held high.
- Echo latency: 0 cycles (combinational), full rate with no bubbles.
- ALU request: `alu_valid` rises the cycle after the 4th operand byte is accepted.
- SEND: the first result byte is valid the cycle after `alu_done` (or after the last operand word when there is only one word).
- `s_axis_tready` is low in DISPATCH, ALU_REQ, ALU_WAIT and SEND. Input bytes are never dropped, only stalled.
- `err` asserts in the DISPATCH cycle only.
- The 16-bit LEN and counter need no wrap handling; the maximum payload is 65531 bytes.

## Test plan
- Echo, with a stub ALU that has 3-cycle `alu_ready` and 2-cycle `alu_done` latency throughout:
  - Stimulus: EC 00 08 00 DE AD BE EF.
  - Response: tx bytes DE AD BE EF in order; no ALU request; `busy` falls after the 8th byte.
- ADD of two words: AD 00 0C 00 01 00 00 00 02 00 00 00.
  - Response: one request with a=1, b=2, op=0.
  - With the stub returning 3: tx 03 00 00 00.
- MUL of three words: 88 00 10 00 with words 2, 3, 0x80000000.
  - Response: requests (2,3), then (6,0x80000000).
  - With the stub returning 0: tx 00 00 00 00.
- Errors:
  - Opcode 55, LEN=6: `err` pulse, 2 bytes drained, no tx.
  - AD with LEN=0x0A: `err` pulse, 6 bytes drained.
  - A following echo packet is handled correctly after each.
- Backpressure: hold `m_axis_tready` low for 10 cycles during SEND and ECHO. Bytes stay stable with no loss or duplication.
- Reset while `alu_valid`=1: all outputs return to reset values. The next echo packet works normally.
